// File: rtl/adc_frame_streamer.sv
// One-frame ADC capture buffer replayed as a valid/ready stream with sof/eof markers.
// The synchronous buffer read is prefetched so a full-rate stream needs no bubbles.
module adc_frame_streamer #(
  parameter int SAMPLE_W  = 8,
  parameter int DATA_SIZE = 1000,
  parameter int ADDR_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                start,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_sof,
  output logic                out_eof,
  output logic                frame_ready,
  output logic                busy,
  output logic                overflow
);

  typedef enum logic [1:0] {CAPTURE, FULL, PRIME, STREAM} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DATA_SIZE - 1);

  state_t              state, state_nx;
  logic [SAMPLE_W-1:0] mem [DATA_SIZE];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr, rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic                wr_en, rd_en, handshake;
  logic                last_wr, last_rd;

  assign last_wr = (wr_ptr == LAST);
  assign last_rd = (rd_ptr == LAST);

  always_comb begin
    state_nx    = state;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    handshake   = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    frame_ready = 1'b0;
    case (state)
      CAPTURE: begin
        wr_en = adc_valid;
        if (adc_valid && last_wr) state_nx = FULL;
      end
      FULL: begin
        frame_ready = 1'b1;
        if (start) begin
          rd_en    = 1'b1;
          state_nx = PRIME;
        end
      end
      PRIME: begin
        busy     = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        handshake = out_ready;
        // Fetch the next word on the accepting cycle so it is presented right after.
        if (out_ready) begin
          if (last_rd) begin
            state_nx = CAPTURE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = rd_ptr + 1'b1;
          end
        end
      end
      default: state_nx = CAPTURE;
    endcase
  end

  assign out_data = rd_data;
  assign out_sof  = (state == STREAM) && (rd_ptr == '0);
  assign out_eof  = (state == STREAM) && last_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CAPTURE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr_en) wr_ptr <= last_wr ? '0 : wr_ptr + 1'b1;
      if (handshake) rd_ptr <= last_rd ? '0 : rd_ptr + 1'b1;
      if (rd_en) rd_data <= mem[rd_addr];
      if (adc_valid && (state != CAPTURE)) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= adc_data;
  end

endmodule
